// File: rtl/shadow_chain_unloader.sv
// shadow_chain_unloader: requests a shadow-chain dump, packs the serial
// bit stream into WORD_W-bit words (first bit in LSB) and buffers them in a
// show-ahead FIFO drained by a valid/ready consumer.
module shadow_chain_unloader #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic              sh_clk,
  input  logic              sh_rst,
  input  logic              start,
  output logic              dump_en,
  input  logic              ch_out,
  input  logic              ch_out_vld,
  input  logic              ch_out_done,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic              overflow,
  output logic              timeout
);

  localparam int unsigned IdxW  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FcntW = PtrW + 1;
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(WORD_W - 1);
  localparam logic [FcntW-1:0] FifoFull = FcntW'(FIFO_DEPTH);
  localparam logic [IdleW-1:0] IdleMax  = IdleW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StCollect, StFlush, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic              overflow_q, overflow_d;
  logic              timeout_q, timeout_d;

  // Word assembly / FIFO request
  logic [WORD_W-1:0] word_bits;
  logic [WORD_W-1:0] push_data;
  logic              push;
  logic              idle_hit;

  // FIFO storage and pointers
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FcntW-1:0]  fcnt_q;
  logic [WORD_W-1:0] hold_q;
  logic              fifo_full;
  logic              pop;
  logic              do_push;

  assign fifo_full = (fcnt_q == FifoFull);
  assign pop       = word_valid && word_ready;
  // A same-cycle pop frees the slot, so a full FIFO can still accept.
  assign do_push   = push && (!fifo_full || pop);

  // Control state register and dump bookkeeping.
  always_ff @(posedge sh_clk or posedge sh_rst) begin
    if (sh_rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      sreg_q     <= '0;
      bcnt_q     <= '0;
      idle_q     <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sreg_q     <= sreg_d;
      bcnt_q     <= bcnt_d;
      idle_q     <= idle_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic: start handling, bit capture, word push, end-of-dump.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sreg_d     = sreg_q;
    bcnt_d     = bcnt_q;
    idle_d     = idle_q;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    word_bits  = sreg_q;
    push_data  = sreg_q;
    push       = 1'b0;
    idle_hit   = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StCollect;
          idx_d      = '0;
          sreg_d     = '0;
          bcnt_d     = '0;
          idle_d     = '0;
          overflow_d = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      StCollect: begin
        if (ch_out_vld) begin
          word_bits[idx_q] = ch_out;
          if (bcnt_q != '1) bcnt_d = bcnt_q + CNT_W'(1);
          if (idx_q == IdxLast) begin
            push      = 1'b1;
            push_data = word_bits;
            sreg_d    = '0;  // keep upper bits clean for a later partial word
            idx_d     = '0;
          end else begin
            sreg_d = word_bits;
            idx_d  = idx_q + IdxW'(1);
          end
        end
        if (ch_out_vld || ch_out_done) begin
          idle_d = '0;
        end else begin
          idle_d   = idle_q + IdleW'(1);
          idle_hit = (idle_d == IdleMax);
        end
        if (idle_hit) timeout_d = 1'b1;
        // idx_d already reflects a coincident final bit.
        if (ch_out_done || idle_hit) begin
          state_d = (idx_d != '0) ? StFlush : StDone;
        end
      end
      StFlush: begin
        push      = 1'b1;
        push_data = sreg_q;
        sreg_d    = '0;
        idx_d     = '0;
        state_d   = StDone;
      end
    endcase

    if (push && !do_push) overflow_d = 1'b1;
  end

  // FIFO storage; contents need no reset since validity is tracked by fcnt_q.
  always_ff @(posedge sh_clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  // FIFO pointers, occupancy and last-popped word.
  always_ff @(posedge sh_clk or posedge sh_rst) begin
    if (sh_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      hold_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        hold_q   <= mem[rd_ptr_q];
      end
      if (do_push && !pop) begin
        fcnt_q <= fcnt_q + FcntW'(1);
      end else if (pop && !do_push) begin
        fcnt_q <= fcnt_q - FcntW'(1);
      end
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    dump_en    = (state_q == StCollect);
    busy       = (state_q == StCollect) || (state_q == StFlush);
    done       = (state_q == StDone);
    word_valid = (fcnt_q != '0);
    // When empty, show the last word handed out rather than stale storage.
    word_data  = word_valid ? mem[rd_ptr_q] : hold_q;
    bit_count  = bcnt_q;
    overflow   = overflow_q;
    timeout    = timeout_q;
  end

endmodule

// File: tb/tb_shadow_chain_unloader.sv
// Directed self-checking bench for shadow_chain_unloader (WORD_W=32,
// FIFO_DEPTH=8, TIMEOUT=16).
module tb_shadow_chain_unloader;

  logic        sh_clk = 1'b0;
  logic        sh_rst;
  logic        start;
  logic        dump_en;
  logic        ch_out;
  logic        ch_out_vld;
  logic        ch_out_done;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        busy;
  logic        done;
  logic [15:0] bit_count;
  logic        overflow;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] got[$];
  logic [31:0] t1[6];
  logic [31:0] w3[12];
  logic [31:0] exp_w;

  shadow_chain_unloader #(
    .WORD_W    (32),
    .FIFO_DEPTH(8),
    .CNT_W     (16),
    .TIMEOUT   (16)
  ) dut (
    .sh_clk     (sh_clk),
    .sh_rst     (sh_rst),
    .start      (start),
    .dump_en    (dump_en),
    .ch_out     (ch_out),
    .ch_out_vld (ch_out_vld),
    .ch_out_done(ch_out_done),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .done       (done),
    .bit_count  (bit_count),
    .overflow   (overflow),
    .timeout    (timeout)
  );

  always #5 sh_clk = ~sh_clk;

  // Record every word the consumer accepts (sampled mid-cycle).
  always @(negedge sh_clk) begin
    if (!sh_rst && word_valid && word_ready) got.push_back(word_data);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sh_clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] val, input int n, input bit done_last);
    for (int j = 0; j < n; j++) begin
      ch_out      = val[j];
      ch_out_vld  = 1'b1;
      ch_out_done = done_last && (j == n - 1);
      tick();
    end
    ch_out      = 1'b0;
    ch_out_vld  = 1'b0;
    ch_out_done = 1'b0;
  endtask

  task automatic pulse_done();
    ch_out_done = 1'b1;
    tick();
    ch_out_done = 1'b0;
  endtask

  initial begin
    t1[0] = 32'h8000_0001;
    t1[1] = 32'h1234_5678;
    t1[2] = 32'hDEAD_BEEF;
    t1[3] = 32'h0F0F_F0F0;
    t1[4] = 32'hCAFE_BABE;
    t1[5] = 32'hFFFF_FFEB;
    for (int k = 0; k < 12; k++) w3[k] = 32'hC0DE_0000 + 32'(k);

    sh_rst      = 1'b1;
    start       = 1'b0;
    ch_out      = 1'b0;
    ch_out_vld  = 1'b0;
    ch_out_done = 1'b0;
    word_ready  = 1'b1;
    tick();
    tick();
    check_eq("rst_dump_en", dump_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_word_valid", word_valid, 0);
    check_eq("rst_word_data", word_data, 0);
    check_eq("rst_bit_count", bit_count, 0);
    check_eq("rst_flags", {overflow, timeout}, 0);
    sh_rst = 1'b0;
    tick();

    // 166-bit chain: five full words plus a 6-bit partial word.
    got.delete();
    do_start();
    check_eq("t1_dump_en", dump_en, 1);
    check_eq("t1_busy", busy, 1);
    for (int k = 0; k < 5; k++) send_bits(t1[k], 32, 1'b0);
    send_bits(t1[5], 6, 1'b0);
    pulse_done();
    check_eq("t1_done_after1", done, 0);
    check_eq("t1_busy_flush", busy, 1);
    tick();
    check_eq("t1_done_after2", done, 1);
    check_eq("t1_dump_en_off", dump_en, 0);
    check_eq("t1_bit_count", bit_count, 166);
    check_eq("t1_overflow", overflow, 0);
    repeat (4) tick();
    check_eq("t1_nwords", got.size(), 6);
    for (int k = 0; k < 5; k++) check_eq($sformatf("t1_word%0d", k), got[k], t1[k]);
    check_eq("t1_word5_padded", got[5], 32'h0000_002B);

    // 64-bit chain with done coincident with the last bit.
    got.delete();
    do_start();
    send_bits(32'h0123_4567, 32, 1'b0);
    send_bits(32'h89AB_CDEF, 32, 1'b1);
    check_eq("t2_done_after1", done, 1);
    check_eq("t2_bit_count", bit_count, 64);
    repeat (4) tick();
    check_eq("t2_nwords", got.size(), 2);
    check_eq("t2_word0", got[0], 32'h0123_4567);
    check_eq("t2_word1", got[1], 32'h89AB_CDEF);

    // Twelve words into an 8-deep FIFO with the consumer stalled.
    got.delete();
    word_ready = 1'b0;
    do_start();
    for (int k = 0; k < 12; k++) send_bits(w3[k], 32, 1'b0);
    pulse_done();
    check_eq("t3_done", done, 1);
    check_eq("t3_overflow", overflow, 1);
    check_eq("t3_bit_count", bit_count, 384);
    check_eq("t3_word_valid", word_valid, 1);
    check_eq("t3_head", word_data, w3[0]);
    word_ready = 1'b1;
    repeat (12) tick();
    check_eq("t3_nwords", got.size(), 8);
    for (int k = 0; k < 8; k++) check_eq($sformatf("t3_word%0d", k), got[k], w3[k]);
    check_eq("t3_empty", word_valid, 0);
    check_eq("t3_hold_last", word_data, w3[7]);

    // Gapped valid: one bit every third cycle.
    got.delete();
    do_start();
    check_eq("t4_overflow_cleared", overflow, 0);
    exp_w = 32'hA5A5_A5A5;
    for (int j = 0; j < 32; j++) begin
      ch_out     = exp_w[j];
      ch_out_vld = 1'b1;
      tick();
      ch_out_vld = 1'b0;
      tick();
      if (j == 9 || j == 30) check_eq($sformatf("t4_gap_dump_en%0d", j), dump_en, 1);
      tick();
    end
    pulse_done();
    check_eq("t4_done", done, 1);
    check_eq("t4_bit_count", bit_count, 32);
    repeat (3) tick();
    check_eq("t4_nwords", got.size(), 1);
    check_eq("t4_word", got[0], 32'hA5A5_A5A5);

    // Idle timeout with no valid bits at all.
    got.delete();
    do_start();
    repeat (15) tick();
    check_eq("t5_c16_state", {dump_en, done, timeout}, 3'b100);
    tick();
    check_eq("t5_c17_timeout", timeout, 1);
    check_eq("t5_c17_done", done, 1);
    check_eq("t5_bit_count", bit_count, 0);
    check_eq("t5_word_valid", word_valid, 0);
    tick();
    check_eq("t5_nwords", got.size(), 0);

    // Reset in the middle of a word.
    word_ready = 1'b0;
    do_start();
    check_eq("t6_timeout_cleared", timeout, 0);
    send_bits(32'h1234_5678, 32, 1'b0);
    send_bits(32'hFFFF_FFFF, 10, 1'b0);
    check_eq("t6_pre_rst_valid", word_valid, 1);
    sh_rst = 1'b1;
    #1;
    check_eq("t6_rst_dump_en", dump_en, 0);
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_word_valid", word_valid, 0);
    check_eq("t6_rst_bit_count", bit_count, 0);
    tick();
    sh_rst = 1'b0;
    tick();
    got.delete();
    word_ready = 1'b1;
    do_start();
    send_bits(32'h0F0F_0F0F, 32, 1'b0);
    send_bits(32'h0000_0015, 5, 1'b0);
    pulse_done();
    tick();
    check_eq("t6_done", done, 1);
    check_eq("t6_bit_count", bit_count, 37);
    repeat (4) tick();
    check_eq("t6_nwords", got.size(), 2);
    check_eq("t6_word0", got[0], 32'h0F0F_0F0F);
    check_eq("t6_word1_clean", got[1], 32'h0000_0015);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
